// File: rtl/minute_time_counter.sv
// -----------------------------------------------------------------------------
// minute_time_counter
//
// Keeps wall-clock time HH:MM in BCD, from 00:00 to 23:59. Each falling edge of
// the asynchronous 1-minute square wave min_clk advances the time by one minute.
// A one-cycle load request sets the time, but only when the requested value is
// a legal BCD time.
//
// Parameters
//   SYNC_STAGES  flops in the min_clk synchroniser (values below 2 are raised to 2)
//
// Ports
//   clk, rst_n        system clock (rising edge) and async active-low reset
//   min_clk           minute square wave, asynchronous to clk
//   run_en            1 = minute edges advance the time, 0 = edges are discarded
//   load_valid        one-cycle time-set request
//   load_h_t/h_u      BCD hours tens/units to load
//   load_m_t/m_u      BCD minutes tens/units to load
//   load_ack          one-cycle pulse: load accepted
//   load_err          one-cycle pulse: load rejected (illegal time)
//   h_t/h_u/m_t/m_u   current time in BCD
//   min_tick          one-cycle pulse whenever the time advanced by one minute
//   day_tick          one-cycle pulse on the 23:59 -> 00:00 rollover
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module minute_time_counter #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       min_clk,
   input  logic       run_en,
   input  logic       load_valid,
   input  logic [1:0] load_h_t,
   input  logic [3:0] load_h_u,
   input  logic [2:0] load_m_t,
   input  logic [3:0] load_m_u,
   output logic       load_ack,
   output logic       load_err,
   output logic [1:0] h_t,
   output logic [3:0] h_u,
   output logic [2:0] m_t,
   output logic [3:0] m_u,
   output logic       min_tick,
   output logic       day_tick
);

   // A single-flop synchroniser is never acceptable for an asynchronous input.
   localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

   // ---------------------------------------------------------------------------
   // min_clk synchroniser and falling-edge detector
   // ---------------------------------------------------------------------------
   logic [STAGES-1:0] sync_q;
   logic              hist_q;
   logic              fall;

   // Everything resets to 0, so a min_clk that is already high at reset release
   // only looks like a rising edge (ignored), never like a spurious fall.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         hist_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop in the chain samples
         // its predecessor's pre-edge value; blocking here would collapse the
         // synchroniser into a single stage.
         sync_q <= {sync_q[STAGES-2:0], min_clk};
         hist_q <= sync_q[STAGES-1];
      end
   end

   assign fall = hist_q & ~sync_q[STAGES-1];

   // ---------------------------------------------------------------------------
   // Time state
   // ---------------------------------------------------------------------------
   logic [1:0] h_t_q, h_t_d;
   logic [3:0] h_u_q, h_u_d;
   logic [2:0] m_t_q, m_t_d;
   logic [3:0] m_u_q, m_u_d;
   logic       ack_q, ack_d;
   logic       err_q, err_d;
   logic       min_tick_q, min_tick_d;
   logic       day_tick_q, day_tick_d;

   // ---------------------------------------------------------------------------
   // Load validity: hours 00..23, minutes 00..59, every digit proper BCD
   // ---------------------------------------------------------------------------
   logic hours_ok;
   logic load_ok;

   always_comb begin
      // NOTE: every variable assigned in always_comb gets a default first, so
      // no path through the block can leave it unassigned and infer a latch.
      hours_ok = 1'b0;
      if (load_h_t < 2'd2) begin
         hours_ok = (load_h_u <= 4'd9);
      end else if (load_h_t == 2'd2) begin
         hours_ok = (load_h_u <= 4'd3);
      end
      load_ok = hours_ok && (load_m_t <= 3'd5) && (load_m_u <= 4'd9);
   end

   // ---------------------------------------------------------------------------
   // Next-minute value: BCD ripple-carry m_u -> m_t -> h_u -> h_t, 23:59 wraps
   // ---------------------------------------------------------------------------
   logic [1:0] inc_h_t;
   logic [3:0] inc_h_u;
   logic [2:0] inc_m_t;
   logic [3:0] inc_m_u;
   logic       at_last_minute;

   always_comb begin
      inc_h_t = h_t_q;
      inc_h_u = h_u_q;
      inc_m_t = m_t_q;
      inc_m_u = m_u_q;
      at_last_minute = (h_t_q == 2'd2) && (h_u_q == 4'd3) &&
                       (m_t_q == 3'd5) && (m_u_q == 4'd9);

      if (m_u_q != 4'd9) begin
         inc_m_u = m_u_q + 4'd1;
      end else begin
         inc_m_u = 4'd0;
         if (m_t_q != 3'd5) begin
            inc_m_t = m_t_q + 3'd1;
         end else begin
            inc_m_t = 3'd0;
            if ((h_t_q == 2'd2) && (h_u_q == 4'd3)) begin
               inc_h_t = 2'd0;
               inc_h_u = 4'd0;
            end else if (h_u_q == 4'd9) begin
               inc_h_u = 4'd0;
               inc_h_t = h_t_q + 2'd1;
            end else begin
               inc_h_u = h_u_q + 4'd1;
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state selection. A valid load takes priority over a coincident minute
   // edge (the edge is dropped); an invalid load leaves the advance untouched.
   // ---------------------------------------------------------------------------
   logic advance;

   always_comb begin
      h_t_d      = h_t_q;
      h_u_d      = h_u_q;
      m_t_d      = m_t_q;
      m_u_d      = m_u_q;
      ack_d      = load_valid & load_ok;
      err_d      = load_valid & ~load_ok;
      advance    = fall & run_en & ~ack_d;
      min_tick_d = advance;
      day_tick_d = advance & at_last_minute;

      if (ack_d) begin
         h_t_d = load_h_t;
         h_u_d = load_h_u;
         m_t_d = load_m_t;
         m_u_d = load_m_u;
      end else if (advance) begin
         h_t_d = inc_h_t;
         h_u_d = inc_h_u;
         m_t_d = inc_m_t;
         m_u_d = inc_m_u;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: only flip-flops live here (no memory arrays), so resetting
         // every register is cheap and gives a fully defined 00:00 start.
         h_t_q      <= 2'd0;
         h_u_q      <= 4'd0;
         m_t_q      <= 3'd0;
         m_u_q      <= 4'd0;
         ack_q      <= 1'b0;
         err_q      <= 1'b0;
         min_tick_q <= 1'b0;
         day_tick_q <= 1'b0;
      end else begin
         h_t_q      <= h_t_d;
         h_u_q      <= h_u_d;
         m_t_q      <= m_t_d;
         m_u_q      <= m_u_d;
         ack_q      <= ack_d;
         err_q      <= err_d;
         min_tick_q <= min_tick_d;
         day_tick_q <= day_tick_d;
      end
   end

   assign h_t      = h_t_q;
   assign h_u      = h_u_q;
   assign m_t      = m_t_q;
   assign m_u      = m_u_q;
   assign load_ack = ack_q;
   assign load_err = err_q;
   assign min_tick = min_tick_q;
   assign day_tick = day_tick_q;

endmodule

// File: tb/tb_minute_time_counter.sv
// -----------------------------------------------------------------------------
// Testbench for minute_time_counter.
// The reference model holds the time as a plain minute-of-day count (0..1439)
// and knows that a min_clk fall sampled at clk edge k is acted on at edge k+2.
// A compare process checks every output against the model on each falling clk
// edge; directed sequences add literal expectations, then a randomized phase
// runs against the model.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_minute_time_counter;

   localparam int S = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       min_clk = 1'b1;
   logic       run_en = 1'b1;
   logic       load_valid = 1'b0;
   logic [1:0] load_h_t = '0;
   logic [3:0] load_h_u = '0;
   logic [2:0] load_m_t = '0;
   logic [3:0] load_m_u = '0;
   logic       load_ack, load_err, min_tick, day_tick;
   logic [1:0] h_t;
   logic [3:0] h_u;
   logic [2:0] m_t;
   logic [3:0] m_u;

   minute_time_counter #(.SYNC_STAGES(S)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .min_clk    (min_clk),
      .run_en     (run_en),
      .load_valid (load_valid),
      .load_h_t   (load_h_t),
      .load_h_u   (load_h_u),
      .load_m_t   (load_m_t),
      .load_m_u   (load_m_u),
      .load_ack   (load_ack),
      .load_err   (load_err),
      .h_t        (h_t),
      .h_u        (h_u),
      .m_t        (m_t),
      .m_u        (m_u),
      .min_tick   (min_tick),
      .day_tick   (day_tick)
   );

   always #5 clk = ~clk;

   // ---------------------------------------------------------------------------
   // Bookkeeping
   // ---------------------------------------------------------------------------
   int n_checks = 0;
   int n_pass   = 0;
   bit cmp_en   = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   function automatic logic [12:0] bcd(input int hh, input int mm);
      return {2'(hh / 10), 4'(hh % 10), 3'(mm / 10), 4'(mm % 10)};
   endfunction

   wire [12:0] dut_time = {h_t, h_u, m_t, m_u};

   // ---------------------------------------------------------------------------
   // Reference model
   // ---------------------------------------------------------------------------
   function automatic bit legal_time(input int ht, input int hu, input int mt, input int mu);
      return (hu <= 9) && (mu <= 9) && (mt <= 5) && (ht * 10 + hu <= 23);
   endfunction

   int         m_min  = 0;      // minute of day
   bit         m_ack  = 1'b0;
   bit         m_err  = 1'b0;
   bit         m_tick = 1'b0;
   bit         m_day  = 1'b0;
   logic [S:0] smp    = '0;     // smp[i] = min_clk as sampled i+1 edges ago
   bit         ld_ok;
   bit         m_fall;

   always_comb ld_ok = legal_time(int'(load_h_t), int'(load_h_u), int'(load_m_t), int'(load_m_u));
   // A fall sampled at edge k (1 at k-1, 0 at k) takes effect at edge k+S.
   always_comb m_fall = smp[S] & ~smp[S-1];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_min  <= 0;
         m_ack  <= 1'b0;
         m_err  <= 1'b0;
         m_tick <= 1'b0;
         m_day  <= 1'b0;
         smp    <= '0;
      end else begin
         m_ack  <= load_valid && ld_ok;
         m_err  <= load_valid && !ld_ok;
         m_tick <= m_fall && run_en && !(load_valid && ld_ok);
         m_day  <= m_fall && run_en && !(load_valid && ld_ok) && (m_min == 1439);
         if (load_valid && ld_ok)
            m_min <= (int'(load_h_t) * 10 + int'(load_h_u)) * 60 + int'(load_m_t) * 10 + int'(load_m_u);
         else if (m_fall && run_en)
            m_min <= (m_min + 1) % 1440;
         smp <= {smp[S-1:0], min_clk};
      end
   end

   // ---------------------------------------------------------------------------
   // Per-cycle compare and range assertion
   // ---------------------------------------------------------------------------
   always @(negedge clk) begin
      if (cmp_en) begin
         check("cycle", {15'd0, dut_time, min_tick, day_tick, load_ack, load_err},
               {15'd0, bcd(m_min / 60, m_min % 60), m_tick, m_day, m_ack, m_err});
         n_checks++;
         assert ((h_u <= 4'd9) && (m_u <= 4'd9) && (m_t <= 3'd5) && (int'(h_t) * 10 + int'(h_u) <= 23))
            n_pass++;
         else
            $display("FAIL bcd_range: got %0h, expected a legal BCD time (t=%0t)", dut_time, $time);
      end
   end

   // ---------------------------------------------------------------------------
   // Stimulus helpers (called and returning on a falling clk edge)
   // ---------------------------------------------------------------------------
   task automatic do_load(input int ht, input int hu, input int mt, input int mu);
      load_valid = 1'b1;
      load_h_t = 2'(ht);
      load_h_u = 4'(hu);
      load_m_t = 3'(mt);
      load_m_u = 4'(mu);
      @(negedge clk);
      load_valid = 1'b0;
   endtask

   // One full min_clk period; counts tick pulses seen within a bounded window.
   task automatic minute_edge(output int ticks, output int days, output int both);
      ticks = 0; days = 0; both = 0;
      min_clk = 1'b1;
      repeat (4) @(negedge clk);
      min_clk = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (min_tick === 1'b1) ticks++;
         if (day_tick === 1'b1) days++;
         if (min_tick === 1'b1 && day_tick === 1'b1) both++;
      end
   endtask

   // Arms a fall that takes effect at the edge following the task's return.
   task automatic arm_fall();
      min_clk = 1'b1;
      repeat (4) @(negedge clk);
      min_clk = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   // ---------------------------------------------------------------------------
   // Main sequence
   // ---------------------------------------------------------------------------
   initial begin
      int ticks, days, both, acks, r, hh, mm;

      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      cmp_en = 1'b1;
      check("reset_time", dut_time, bcd(0, 0));
      check("reset_pulses", {min_tick, day_tick, load_ack, load_err}, 4'b0000);

      // min_clk held high through reset: no fall; then one fall, 3-edge latency
      repeat (4) @(negedge clk);
      check("no_spurious_tick", dut_time, bcd(0, 0));
      min_clk = 1'b0;
      for (int e = 1; e <= 3; e++) begin
         @(posedge clk);
         #1;
         check($sformatf("latency_edge%0d", e), min_tick, (e == 3) ? 1 : 0);
      end
      @(negedge clk);
      check("first_minute", dut_time, bcd(0, 1));
      @(negedge clk);
      check("tick_one_cycle", min_tick, 1'b0);

      // 09:59 -> 10:00
      do_load(0, 9, 5, 9);
      check("load_0959_ack", {load_ack, load_err}, 2'b10);
      check("load_0959_time", dut_time, bcd(9, 59));
      minute_edge(ticks, days, both);
      check("carry_hour_ticks", ticks, 1);
      check("carry_hour_days", days, 0);
      check("carry_hour_time", dut_time, bcd(10, 0));

      // 23:59 -> 00:00 with day_tick
      do_load(2, 3, 5, 9);
      check("load_2359_ack", load_ack, 1'b1);
      minute_edge(ticks, days, both);
      check("rollover_ticks", ticks, 1);
      check("rollover_days", days, 1);
      check("rollover_same_cycle", both, 1);
      check("rollover_time", dut_time, bcd(0, 0));

      // Illegal loads leave the time alone
      do_load(2, 4, 0, 0);
      check("err_2400", {load_ack, load_err}, 2'b01);
      check("err_2400_time", dut_time, bcd(0, 0));
      do_load(1, 9, 6, 0);
      check("err_1960", {load_ack, load_err}, 2'b01);
      check("err_1960_time", dut_time, bcd(0, 0));
      do_load(1, 10, 0, 0);
      check("err_1A00", {load_ack, load_err}, 2'b01);
      check("err_1A00_time", dut_time, bcd(0, 0));

      // Valid load coinciding with fall: load wins, edge dropped
      arm_fall();
      do_load(1, 2, 3, 4);
      check("coinc_valid_time", dut_time, bcd(12, 34));
      check("coinc_valid_flags", {min_tick, day_tick, load_ack, load_err}, 4'b0010);
      repeat (4) @(negedge clk);
      check("coinc_valid_dropped", dut_time, bcd(12, 34));

      // Invalid load coinciding with fall: error and normal advance
      arm_fall();
      do_load(2, 5, 0, 0);
      check("coinc_invalid_time", dut_time, bcd(12, 35));
      check("coinc_invalid_flags", {min_tick, day_tick, load_ack, load_err}, 4'b1001);

      // load_valid held three cycles -> three acks
      acks = 0;
      load_valid = 1'b1;
      load_h_t = 2'd0; load_h_u = 4'd8; load_m_t = 3'd1; load_m_u = 4'd5;
      repeat (3) begin
         @(negedge clk);
         if (load_ack === 1'b1) acks++;
      end
      load_valid = 1'b0;
      @(negedge clk);
      if (load_ack === 1'b1) acks++;
      check("held_load_acks", acks, 3);
      check("held_load_time", dut_time, bcd(8, 15));

      // run_en=0 discards edges
      run_en = 1'b0;
      acks = 0;
      repeat (3) begin
         minute_edge(ticks, days, both);
         acks += ticks;
      end
      check("frozen_ticks", acks, 0);
      check("frozen_time", dut_time, bcd(8, 15));
      run_en = 1'b1;
      minute_edge(ticks, days, both);
      check("resume_ticks", ticks, 1);
      check("resume_time", dut_time, bcd(8, 16));

      // Async reset with a fall in flight
      min_clk = 1'b1;
      repeat (4) @(negedge clk);
      min_clk = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async_reset_time", dut_time, bcd(0, 0));
      check("async_reset_pulses", {min_tick, day_tick, load_ack, load_err}, 4'b0000);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      ticks = 0;
      repeat (8) begin
         @(negedge clk);
         if (min_tick === 1'b1) ticks++;
      end
      check("post_reset_ticks", ticks, 0);
      check("post_reset_time", dut_time, bcd(0, 0));

      // Randomized phase, checked by the compare process every cycle
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(3) == 0) min_clk = ~min_clk;
         run_en = ($urandom_range(9) != 0);
         if ($urandom_range(7) == 0) begin
            load_valid = 1'b1;
            r = $urandom_range(3);
            if (r == 0) begin
               load_h_t = 2'($urandom_range(3));
               load_h_u = 4'($urandom_range(15));
               load_m_t = 3'($urandom_range(7));
               load_m_u = 4'($urandom_range(15));
            end else begin
               hh = (r == 1) ? 23 : int'($urandom_range(23));
               mm = (r == 1) ? 58 + int'($urandom_range(1)) : int'($urandom_range(59));
               load_h_t = 2'(hh / 10);
               load_h_u = 4'(hh % 10);
               load_m_t = 3'(mm / 10);
               load_m_u = 4'(mm % 10);
            end
         end else begin
            load_valid = 1'b0;
         end
         @(negedge clk);
      end
      load_valid = 1'b0;
      repeat (5) @(negedge clk);
      cmp_en = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/minute_time_counter.md
Name: minute_time_counter

Overview:
- Consumes the 1-minute square wave from the minute clock generator and keeps wall-clock time HH:MM in BCD, 00:00 to 23:59.
- Each falling edge of min_clk advances time by one minute.
- min_clk is treated as asynchronous. It is synchronised into the system clock domain and edge-detected.
- Provides a validated load (time-set) interface and a day-rollover pulse for downstream display and alarm logic.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in the min_clk synchroniser (minimum 2).

Ports:
- clk  input  1  system clock; all state on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- min_clk  input  1  minute square wave; asynchronous to clk; each falling edge equals one minute.
- run_en  input  1  1 = minute edges advance time; 0 = time frozen (edges discarded).
- load_valid  input  1  one-cycle request to set the time.
- load_h_t  input  2  BCD hours tens.
- load_h_u  input  4  BCD hours units.
- load_m_t  input  3  BCD minutes tens.
- load_m_u  input  4  BCD minutes units.
- load_ack  output  1  one-cycle pulse: load accepted.
- load_err  output  1  one-cycle pulse: load rejected (invalid BCD time).
- h_t  output  2  current hours tens.
- h_u  output  4  current hours units.
- m_t  output  3  current minutes tens.
- m_u  output  4  current minutes units.
- min_tick  output  1  one-cycle pulse whenever time advanced by one minute.
- day_tick  output  1  one-cycle pulse on the 23:59 to 00:00 rollover.

Behaviour:
- Reset (async assert, sync release):
  - all synchroniser flops = 0;
  - edge-history flop = 0;
  - time = 00:00;
  - load_ack = load_err = min_tick = day_tick = 0.
  - Reset mid-operation discards any pending edge or load immediately.
- Synchroniser: SYNC_STAGES flops, then one history flop.
  - fall = history & ~sync_out.
  - Because all flops reset to 0, a min_clk held high or low through reset release never generates a spurious fall.
  - Rising edges are ignored.
- Latency (SYNC_STAGES=2): a min_clk fall captured at clk edge k gives fall=1 after edge k+1. Time, min_tick and day_tick update at edge k+2. Outputs are registered.
- Advance (fall=1, run_en=1, no load_valid):
  - m_u increments; at 9 it goes to 0 and carries into m_t.
  - m_t wraps 5 to 0 and carries into hours.
  - Hours: h_u increments; at 9 it goes to 0 and carries into h_t.
  - From 23, hours go to 00.
  - min_tick=1 for one cycle. day_tick=1 only on the 23:59 to 00:00 step.
- run_en=0: fall is consumed (not queued); time holds; min_tick and day_tick stay 0.
- Load validity check:
  - h_t ≤ 2;
  - h_u ≤ 9;
  - if h_t = 2 then h_u ≤ 3;
  - m_t ≤ 5;
  - m_u ≤ 9.
- Load result, registered one cycle after load_valid:
  - valid: time takes the loaded value and load_ack=1;
  - invalid: time unchanged and load_err=1.
  - load_ack and load_err are never both 1.
- Simultaneous load_valid and fall (run_en=1):
  - a valid load wins; the minute edge is dropped; min_tick=0; day_tick=0.
  - an invalid load gives load_err=1 and the minute advance proceeds normally.
- load_valid held high for N cycles is processed every cycle: N acks or errors.
- Loading 23:59 then receiving one edge produces the normal rollover with day_tick.
- Time registers never hold a non-BCD or out-of-range value. This is required as an assertion in the bench.
- Implementation size: roughly 150–250 lines.

Test Plan:
- Reset with min_clk=1, then toggle min_clk low once -> exactly one min_tick; time 00:01; fall-to-update latency exactly 3 clk rising edges.
- Load 09:59 (valid) then one min_clk fall -> load_ack pulse; time 10:00; min_tick=1; day_tick=0.
- Load 23:59 then one fall -> time 00:00; min_tick=1 and day_tick=1 in the same single cycle.
- Load 24:00, then 19:60, then 1A:00 (h_u=4'hA) -> load_err pulse each time, time unchanged at previous value, load_ack=0.
- Drive load_valid=1 (12:34) in the same cycle fall=1 -> time 12:34, min_tick=0; repeat with invalid load 25:00 -> load_err=1 and time advances by one minute.
- run_en=0 across 3 min_clk falls, then run_en=1 and 1 fall -> time advances by exactly 1 minute total; assert rst_n low mid-run -> outputs 00:00 asynchronously, no tick after release.
